mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle control FSM that sequences the instruction fetch unit and the datapath for the MIPS core. Each instruction runs through FETCH/DECODE/EXEC/MEM/WB.
- The block asserts the IFU PC write enable and `npc_sel` exactly once per retired instruction.
- It issues data-memory requests with a ready handshake and timeout.
- It counts retired instructions and traps on illegal opcodes.

Parameters:
- INSTRET_W, 32, width of retired-instruction counter.
- MEM_TIMEOUT, 16, max cycles spent in MEM waiting for mem_ready before trap (range 1..255).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  32  current instruction from IFU; stable while pc_en=0.
- zero  in  1  ALU equality flag, valid in EXEC.
- mem_ready  in  1  data memory completion for the current request.
- state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- pc_en  out  1  IFU PC update strobe; one cycle per instruction.
- npc_sel  out  2  IFU next-PC select: NORM=00, RELATIVE=01, IRRELATIVE=10, REGISTER=11 (the `IFU_SEL_*` values in defines.v).
- reg_we  out  1  register file write enable.
- reg_dst  out  2  write register: 0=rt, 1=rd, 2=$31.
- wd_sel  out  2  write data: 0=ALU, 1=mem, 2=PC+4.
- alu_src  out  1  0=rt, 1=extended immediate.
- ext_op  out  2  0=zero-ext, 1=sign-ext, 2=imm<<16.
- alu_op  out  2  0=add, 1=sub, 2=or.
- mem_req  out  1  data memory request.
- mem_we  out  1  store qualifier for mem_req.
- exc  out  1  sticky trap flag.
- instret  out  INSTRET_W  retired-instruction count.

Behaviour:
- Reset (async, reset=0):
  - state=FETCH, instret=0, exc=0, timeout counter=0.
  - All strobes (pc_en, reg_we, mem_req, mem_we) =0; npc_sel=NORM.
  - Reset asserted mid-instruction aborts the instruction with no retire.
- State register, instret, exc and timeout counter are registered. All other outputs decode combinationally from state, inst and zero.
- Decode:
  - Opcode inst[31:26]; funct inst[5:0] for R-type.
  - NOP is inst==0.
  - R-type funct values other than addu 100001, subu 100011 and jr 001000 are illegal.
- Sequences (pc_en asserted in the listed final cycle only):
  - nop: F,D; final D, NORM.
  - j (000010): F,D; final D, IRRELATIVE.
  - jr: F,D; final D, REGISTER.
  - jal (000011): F,D,WB; WB has reg_we=1, reg_dst=2, wd_sel=2, IRRELATIVE.
  - addu/subu: F,D,E,WB. E has alu_src=0, alu_op=0/1. WB has reg_we=1, reg_dst=1, wd_sel=0, NORM.
  - ori (001101): F,D,E,WB. E has ext_op=0, alu_src=1, alu_op=2. WB writes rt, NORM.
  - lui (001111): like ori but ext_op=2, alu_op=2 (or with $0 operand).
  - beq (000100): F,D,E. E has alu_op=1; final E with npc_sel=RELATIVE if zero else NORM.
  - lw (100011): F,D,E,M,WB. E/M have ext_op=1, alu_src=1, alu_op=0. M holds mem_req=1, mem_we=0. WB has wd_sel=1, reg_dst=0, reg_we=1, NORM.
  - sw (101011): F,D,E,M. M holds mem_req=1, mem_we=1. Final is the M cycle where mem_ready=1, NORM.
- Control outputs not listed for a state are held at 0 (npc_sel NORM).
- MEM handshake:
  - mem_req holds until mem_ready is sampled high.
  - The timeout counter clears on MEM entry and increments each MEM cycle with mem_ready=0.
  - If the count reaches MEM_TIMEOUT: go to TRAP, no retire.
  - mem_ready=1 on the timeout cycle wins (completes normally).
  - mem_ready outside MEM is ignored.
- Retire: each final cycle sets pc_en=1, instret+=1 (wraps modulo 2^INSTRET_W), next state FETCH.
- Illegal opcode/funct in DECODE:
  - Go to TRAP; exc=1.
  - TRAP holds: no pc_en, reg_we or mem_req; exc sticky.
  - Exit only via reset.
- pc_en is never asserted in FETCH or TRAP, and never for two consecutive cycles.

Test Plan:
- Reset release, inst=0 → state 0,1,0,1…; pc_en high every 2nd cycle with npc_sel=00; instret=3 after 6 cycles.
- inst=0x10000003 (beq): zero=1 → pc_en in EXEC with npc_sel=01; repeat with zero=0 → npc_sel=00; instret increments each time.
- inst=0x8C010004 (lw), mem_ready low 3 MEM cycles then high → mem_req high 4 cycles, mem_we=0; WB has reg_we=1, wd_sel=1; total 7 cycles to pc_en.
- inst=0xAC010004 (sw), mem_ready never high, MEM_TIMEOUT=16 → TRAP after 16 MEM cycles, exc=1; instret unchanged; pc_en stays 0 for 50 further cycles.
- inst=0x0C000C02 (jal) then 0x03E00008 (jr) → jal: WB reg_we=1, reg_dst=2, wd_sel=2, npc_sel=10; jr: pc_en in DECODE with npc_sel=11.
- inst=0xFC000000 (illegal) → TRAP in cycle 2, exc=1; reset pulse low mid-TRAP → state=0, exc=0, instret=0.

Source files
------------

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS sequencer, the IFU and the datapath.
// The master modport is the sequencer and the slave modport is the IFU/datapath side.
interface mips_mc_ctrl_if #(
    parameter int INSTRET_W = 32
);
    logic [31:0]          inst;
    logic                 zero;
    logic                 mem_ready;
    logic [2:0]           state;
    logic                 pc_en;
    logic [1:0]           npc_sel;
    logic                 reg_we;
    logic [1:0]           reg_dst;
    logic [1:0]           wd_sel;
    logic                 alu_src;
    logic [1:0]           ext_op;
    logic [1:0]           alu_op;
    logic                 mem_req;
    logic                 mem_we;
    logic                 exc;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  inst, zero, mem_ready,
        output state, pc_en, npc_sel, reg_we, reg_dst, wd_sel, alu_src,
               ext_op, alu_op, mem_req, mem_we, exc, instret
    );

    modport slave (
        output inst, zero, mem_ready,
        input  state, pc_en, npc_sel, reg_we, reg_dst, wd_sel, alu_src,
               ext_op, alu_op, mem_req, mem_we, exc, instret
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS core: drives the IFU PC strobe,
// the datapath selects and the data-memory handshake, counts retires and traps on illegal opcodes.
module mips_mc_ctrl #(
    parameter int INSTRET_W   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    mips_mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    localparam logic [1:0] NPC_NORM = 2'b00;
    localparam logic [1:0] NPC_REL  = 2'b01;
    localparam logic [1:0] NPC_IRR  = 2'b10;
    localparam logic [1:0] NPC_REG  = 2'b11;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 exc_q, exc_d;
    logic [7:0]           tmo_q, tmo_d;

    logic [5:0] op, fn;
    logic is_nop, is_r, is_addu, is_subu, is_jr, is_j, is_jal;
    logic is_ori, is_lui, is_beq, is_lw, is_sw, legal;

    assign op      = bus.inst[31:26];
    assign fn      = bus.inst[5:0];
    assign is_nop  = (bus.inst == 32'd0);
    assign is_r    = (op == 6'b000000) && !is_nop;
    assign is_addu = is_r && (fn == 6'b100001);
    assign is_subu = is_r && (fn == 6'b100011);
    assign is_jr   = is_r && (fn == 6'b001000);
    assign is_j    = (op == 6'b000010);
    assign is_jal  = (op == 6'b000011);
    assign is_ori  = (op == 6'b001101);
    assign is_lui  = (op == 6'b001111);
    assign is_beq  = (op == 6'b000100);
    assign is_lw   = (op == 6'b100011);
    assign is_sw   = (op == 6'b101011);
    assign legal   = is_nop | is_addu | is_subu | is_jr | is_j | is_jal |
                     is_ori | is_lui | is_beq | is_lw | is_sw;

    always_comb begin
        state_d     = state_q;
        exc_d       = exc_q;
        tmo_d       = tmo_q;
        bus.pc_en   = 1'b0;
        bus.npc_sel = NPC_NORM;
        bus.reg_we  = 1'b0;
        bus.reg_dst = 2'd0;
        bus.wd_sel  = 2'd0;
        bus.alu_src = 1'b0;
        bus.ext_op  = 2'd0;
        bus.alu_op  = 2'd0;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;

        unique case (state_q)
            S_FETCH: state_d = S_DECODE;

            S_DECODE: begin
                if (!legal) begin
                    state_d = S_TRAP;
                    exc_d   = 1'b1;
                end else if (is_nop || is_j || is_jr) begin
                    bus.pc_en   = 1'b1;
                    bus.npc_sel = is_j ? NPC_IRR : (is_jr ? NPC_REG : NPC_NORM);
                    state_d     = S_FETCH;
                end else if (is_jal) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (is_addu || is_subu) begin
                    bus.alu_op = is_subu ? 2'd1 : 2'd0;
                    state_d    = S_WB;
                end else if (is_ori || is_lui) begin
                    bus.ext_op  = is_lui ? 2'd2 : 2'd0;
                    bus.alu_src = 1'b1;
                    bus.alu_op  = 2'd2;
                    state_d     = S_WB;
                end else if (is_beq) begin
                    bus.alu_op  = 2'd1;
                    bus.pc_en   = 1'b1;
                    bus.npc_sel = bus.zero ? NPC_REL : NPC_NORM;
                    state_d     = S_FETCH;
                end else begin
                    bus.ext_op  = 2'd1;
                    bus.alu_src = 1'b1;
                    state_d     = S_MEM;
                    tmo_d       = 8'd0;
                end
            end

            S_MEM: begin
                bus.ext_op  = 2'd1;
                bus.alu_src = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = is_sw;
                // A completion on the last allowed cycle still beats the timeout.
                if (bus.mem_ready) begin
                    if (is_sw) begin
                        bus.pc_en = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                    exc_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            S_WB: begin
                bus.reg_we = 1'b1;
                bus.pc_en  = 1'b1;
                state_d    = S_FETCH;
                if (is_jal) begin
                    bus.reg_dst = 2'd2;
                    bus.wd_sel  = 2'd2;
                    bus.npc_sel = NPC_IRR;
                end else if (is_addu || is_subu) begin
                    bus.reg_dst = 2'd1;
                end else if (is_lw) begin
                    bus.wd_sel = 2'd1;
                end
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_FETCH;
        endcase

        instret_d = instret_q + INSTRET_W'(bus.pc_en);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            exc_q     <= 1'b0;
            tmo_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            exc_q     <= exc_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.instret = instret_q;
    assign bus.exc     = exc_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for the multi-cycle sequencer: walks each instruction class cycle by cycle
// against hand-derived state/strobe values, including the MEM timeout and trap/reset recovery.
module tb_mips_mc_ctrl;
    localparam int INSTRET_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mips_mc_ctrl_if #(.INSTRET_W(INSTRET_W)) bus ();

    mips_mc_ctrl #(.INSTRET_W(INSTRET_W), .MEM_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [31:0] v);
        bus.inst = v;
        #1;
    endtask

    initial begin
        int n;
        bus.inst      = 32'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // reset state
        #12;
        chk("rst_state", bus.state, 0);
        chk("rst_instret", bus.instret, 0);
        chk("rst_exc", bus.exc, 0);
        chk("rst_pc_en", bus.pc_en, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;

        // nop stream: F,D,F,D...
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("nop_state", bus.state, (c % 2 == 1) ? 1 : 0);
            chk("nop_pc_en", bus.pc_en, (c % 2 == 1) ? 1 : 0);
            chk("nop_npc", bus.npc_sel, 0);
        end
        chk("nop_instret", bus.instret, 3);

        // beq taken then not taken
        set_inst(32'h1000_0003);
        bus.zero = 1'b1;
        tick(); chk("beq_d_pc_en", bus.pc_en, 0);
        tick(); chk("beq_e_state", bus.state, 2);
        chk("beq_e_alu_op", bus.alu_op, 1);
        chk("beq_t_pc_en", bus.pc_en, 1);
        chk("beq_t_npc", bus.npc_sel, 1);
        bus.zero = 1'b0; #1;
        chk("beq_nt_npc", bus.npc_sel, 0);
        tick(); chk("beq_instret", bus.instret, 4);
        tick(); tick();
        chk("beq2_pc_en", bus.pc_en, 1);
        chk("beq2_npc", bus.npc_sel, 0);
        tick(); chk("beq2_instret", bus.instret, 5);

        // lw with three wait cycles
        set_inst(32'h8C01_0004);
        tick(); tick();
        chk("lw_e_state", bus.state, 2);
        chk("lw_e_ext", bus.ext_op, 1);
        chk("lw_e_alu_src", bus.alu_src, 1);
        chk("lw_e_mem_req", bus.mem_req, 0);
        n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 3) begin bus.mem_ready = 1'b1; #1; end
            chk("lw_m_state", bus.state, 3);
            chk("lw_m_we", bus.mem_we, 0);
            chk("lw_m_pc_en", bus.pc_en, 0);
            n += int'(bus.mem_req);
        end
        chk("lw_req_cycles", n, 4);
        tick();
        bus.mem_ready = 1'b0; #1;
        chk("lw_wb_state", bus.state, 4);
        chk("lw_wb_reg_we", bus.reg_we, 1);
        chk("lw_wb_wd_sel", bus.wd_sel, 1);
        chk("lw_wb_reg_dst", bus.reg_dst, 0);
        chk("lw_wb_pc_en", bus.pc_en, 1);
        chk("lw_wb_mem_req", bus.mem_req, 0);
        tick(); chk("lw_instret", bus.instret, 6);

        // jal then jr
        set_inst(32'h0C00_0C02);
        tick(); chk("jal_d_pc_en", bus.pc_en, 0);
        tick(); chk("jal_wb_state", bus.state, 4);
        chk("jal_wb_ctl", {bus.reg_we, bus.reg_dst, bus.wd_sel, bus.npc_sel, bus.pc_en},
            {1'b1, 2'd2, 2'd2, 2'b10, 1'b1});
        tick(); set_inst(32'h03E0_0008);
        tick(); chk("jr_d_pc_en", bus.pc_en, 1);
        chk("jr_d_npc", bus.npc_sel, 3);
        tick(); chk("jr_instret", bus.instret, 8);

        // addu, subu, ori, lui execute-stage selects and writeback
        set_inst(32'h0022_1821);
        tick(); tick();
        chk("addu_e", {bus.alu_src, bus.alu_op, bus.pc_en}, {1'b0, 2'd0, 1'b0});
        tick(); chk("addu_wb", {bus.reg_we, bus.reg_dst, bus.wd_sel, bus.pc_en}, {1'b1, 2'd1, 2'd0, 1'b1});
        tick(); set_inst(32'h0022_1823);
        tick(); tick(); chk("subu_e_alu_op", bus.alu_op, 1);
        tick(); tick(); set_inst(32'h3422_0005);
        tick(); tick();
        chk("ori_e", {bus.ext_op, bus.alu_src, bus.alu_op}, {2'd0, 1'b1, 2'd2});
        tick(); chk("ori_wb", {bus.reg_we, bus.reg_dst, bus.wd_sel}, {1'b1, 2'd0, 2'd0});
        tick(); set_inst(32'h3C01_1234);
        tick(); tick();
        chk("lui_e", {bus.ext_op, bus.alu_src, bus.alu_op}, {2'd2, 1'b1, 2'd2});
        tick(); tick(); set_inst(32'h0800_0000);
        tick(); chk("j_d_npc", bus.npc_sel, 2);
        chk("j_d_pc_en", bus.pc_en, 1);
        tick(); chk("j_instret", bus.instret, 13);

        // sw completing on the 16th MEM cycle beats the timeout
        set_inst(32'hAC01_0004);
        tick(); tick(); tick();
        for (int c = 0; c < 15; c++) tick();
        chk("sw_edge_we", bus.mem_we, 1);
        bus.mem_ready = 1'b1; #1;
        chk("sw_edge_state", bus.state, 3);
        chk("sw_edge_pc_en", bus.pc_en, 1);
        tick(); bus.mem_ready = 1'b0; #1;
        chk("sw_edge_back", bus.state, 0);
        chk("sw_edge_instret", bus.instret, 14);

        // sw timing out traps after 16 MEM cycles
        tick(); tick();
        n = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            n += int'(bus.state == 3'd3 && bus.mem_req && bus.mem_we);
        end
        chk("sw_tmo_mem_cycles", n, 16);
        tick();
        chk("sw_tmo_state", bus.state, 7);
        chk("sw_tmo_exc", bus.exc, 1);
        chk("sw_tmo_instret", bus.instret, 14);
        n = 0;
        for (int c = 0; c < 50; c++) begin
            bus.mem_ready = c[0]; #1;
            n += int'(bus.pc_en | bus.reg_we | bus.mem_req);
            tick();
        end
        chk("trap_strobes", n, 0);
        chk("trap_hold", bus.state, 7);
        chk("trap_instret", bus.instret, 14);

        // illegal opcode, then async reset mid-trap
        bus.mem_ready = 1'b0;
        reset = 1'b0; #2;
        chk("rst2_state", bus.state, 0);
        chk("rst2_exc", bus.exc, 0);
        set_inst(32'hFC00_0000);
        @(negedge clk); reset = 1'b1; #1;
        tick(); chk("ill_d_state", bus.state, 1);
        chk("ill_d_exc", bus.exc, 0);
        tick(); chk("ill_state", bus.state, 7);
        chk("ill_exc", bus.exc, 1);
        tick(); tick();
        #2 reset = 1'b0; #1;
        chk("rst3_state", bus.state, 0);
        chk("rst3_exc", bus.exc, 0);
        chk("rst3_instret", bus.instret, 0);

        // illegal R-type funct (add) also traps
        set_inst(32'h0022_1820);
        @(negedge clk); reset = 1'b1; #1;
        tick(); tick();
        chk("ill_r_state", bus.state, 7);
        chk("ill_r_exc", bus.exc, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
